// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   state_t   : receive FSM states
//   OS_TICKS  : oversample ticks per bit period
//   MID_TICK  : tick index at the middle of the start bit
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int OS_TICKS = 16;
    localparam int MID_TICK = 7;

endpackage

// File: rtl/baud_rate_generator.sv
// ---------------------------------------------------------------------------
// baud_rate_generator
// Free-running divider producing a one-clk oversample tick every DIVISOR
// clock cycles. Can be shared between the receiver and transmitter.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset, returns the count to 0
//   s_tick out  one-clk strobe every DIVISOR cycles
// ---------------------------------------------------------------------------
module baud_rate_generator #(
    parameter int DIVISOR = 651
) (
    input  logic clk,
    input  logic reset,
    output logic s_tick
);

    localparam int              CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign s_tick = (r_count == LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer
// Receive front end of the UART: synchronizes the serial line, samples it at
// 16x baud and deframes start/data/parity/stop bits into parallel words.
// Ports:
//   clk            in   system clock (rising edge)
//   reset          in   synchronous active-high reset
//   rx             in   asynchronous serial line, idles high
//   fifo_full      in   full flag of the downstream receive FIFO
//   rx_data        out  last good word, right-aligned, held until the next one
//   rx_done_tick   out  one-clk strobe for a good frame (FIFO write request)
//   frame_error    out  one-clk pulse: stop bit sampled low
//   parity_error   out  one-clk pulse: parity check failed
//   overrun_error  out  one-clk pulse: good frame while fifo_full is high
//   busy           out  high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int SB_TICKS     = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int BAUD_DIVISOR = 651
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 fifo_full,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done_tick,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overrun_error,
    output logic                 busy
);

    // Two stop bits need a 5-bit tick counter to reach 31.
    localparam int            TW          = (SB_TICKS > OS_TICKS) ? 5 : 4;
    localparam logic [TW-1:0] MID         = TW'(MID_TICK);
    localparam logic [TW-1:0] LAST_OS     = TW'(OS_TICKS - 1);
    localparam logic [TW-1:0] LAST_SB     = TW'(SB_TICKS - 1);
    localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);
    localparam logic          PAR_ODD_BIT = (PARITY_ODD != 0);
    localparam logic          HAS_PARITY  = (PARITY_EN != 0);

    logic                 w_s_tick;
    logic                 w_rx_s;
    logic                 w_stop_val;
    logic                 w_par_ok;

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_xor;
    logic                 r_par_ok;
    logic                 r_stop_bit;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_done;
    logic                 r_fe;
    logic                 r_pe;
    logic                 r_ov;

    baud_rate_generator #(
        .DIVISOR (BAUD_DIVISOR)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .s_tick (w_s_tick)
    );

    // Two-flop synchronizer; flops reset to the idle (high) line level so a
    // reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // With a single stop bit the stop sample and the frame evaluation land on
    // the same tick, so the live line value is used instead of the stored one.
    assign w_stop_val = (r_tick_cnt == LAST_OS) ? w_rx_s : r_stop_bit;
    assign w_par_ok   = !HAS_PARITY || r_par_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_xor      <= 1'b0;
            r_par_ok   <= 1'b1;
            r_stop_bit <= 1'b1;
            r_rx_data  <= '0;
            r_done     <= 1'b0;
            r_fe       <= 1'b0;
            r_pe       <= 1'b0;
            r_ov       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_fe   <= 1'b0;
            r_pe   <= 1'b0;
            r_ov   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state    <= START;
                        r_tick_cnt <= '0;
                    end
                end

                START: begin
                    if (w_s_tick) begin
                        if (r_tick_cnt == MID) begin
                            r_tick_cnt <= '0;
                            if (!w_rx_s) begin
                                r_state    <= DATA;
                                r_bit_cnt  <= '0;
                                r_xor      <= 1'b0;
                                r_par_ok   <= 1'b1;
                                r_stop_bit <= 1'b1;
                            end else begin
                                // Line went back high before mid start bit.
                                r_state <= IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (w_s_tick) begin
                        if (r_tick_cnt == LAST_OS) begin
                            r_tick_cnt <= '0;
                            // LSB arrives first, so shift in from the top.
                            r_shreg    <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
                            r_xor      <= r_xor ^ w_rx_s;
                            if (r_bit_cnt == LAST_BIT) begin
                                r_bit_cnt <= '0;
                                r_state   <= HAS_PARITY ? PARITY : STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (w_s_tick) begin
                        if (r_tick_cnt == LAST_OS) begin
                            r_tick_cnt <= '0;
                            r_par_ok   <= ~(r_xor ^ w_rx_s ^ PAR_ODD_BIT);
                            r_state    <= STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (w_s_tick) begin
                        if (r_tick_cnt == LAST_OS) begin
                            r_stop_bit <= w_rx_s;
                        end
                        if (r_tick_cnt == LAST_SB) begin
                            r_tick_cnt <= '0;
                            r_state    <= IDLE;
                            // Frame error outranks parity error.
                            if (!w_stop_val) begin
                                r_fe <= 1'b1;
                            end else if (!w_par_ok) begin
                                r_pe <= 1'b1;
                            end else begin
                                r_rx_data <= r_shreg;
                                r_done    <= 1'b1;
                                r_ov      <= fifo_full;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_done_tick  = r_done;
    assign frame_error   = r_fe;
    assign parity_error  = r_pe;
    assign overrun_error = r_ov;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_rx_deserializer
// Two receivers share one clock: an 8N1 instance and an 8E1 instance. Frames
// are serialized on the chosen line; the expected outcome of each frame is
// queued when it is sent and a monitor pops and compares on every output
// event.
// ---------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    localparam int DIV      = 4;
    localparam int BIT_CLKS = 16 * DIV;

    typedef struct packed {
        logic [3:0] vec;   // {overrun, done, frame_err, parity_err}
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_n = 1'b1;
    logic       rx_p = 1'b1;
    logic       ff_n = 1'b0;
    logic       ff_p = 1'b0;

    logic [7:0] data_n, data_p;
    logic       done_n, fe_n, pe_n, ov_n, busy_n;
    logic       done_p, fe_p, pe_p, ov_p, busy_p;

    exp_t       q_n[$];
    exp_t       q_p[$];
    logic [7:0] last_n = 8'h00;
    logic [7:0] last_p = 8'h00;
    int         tests = 0;
    int         fails = 0;
    bit         stim_done = 1'b0;

    always #5 clk = ~clk;

    uart_rx_deserializer #(
        .DATA_BITS(8), .SB_TICKS(16), .PARITY_EN(0), .PARITY_ODD(0), .BAUD_DIVISOR(DIV)
    ) dut_n (
        .clk(clk), .reset(reset), .rx(rx_n), .fifo_full(ff_n),
        .rx_data(data_n), .rx_done_tick(done_n), .frame_error(fe_n),
        .parity_error(pe_n), .overrun_error(ov_n), .busy(busy_n)
    );

    uart_rx_deserializer #(
        .DATA_BITS(8), .SB_TICKS(16), .PARITY_EN(1), .PARITY_ODD(0), .BAUD_DIVISOR(DIV)
    ) dut_p (
        .clk(clk), .reset(reset), .rx(rx_p), .fifo_full(ff_p),
        .rx_data(data_p), .rx_done_tick(done_p), .frame_error(fe_p),
        .parity_error(pe_p), .overrun_error(ov_p), .busy(busy_p)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_rx(input bit p, input logic v);
        if (p) rx_p = v;
        else   rx_n = v;
    endtask

    task automatic idle_bits(input bit p, input int n);
        set_rx(p, 1'b1);
        wait_clks(n * BIT_CLKS);
    endtask

    // Expected outcome from the framing rules, then the waveform itself.
    task automatic send(input bit p, input logic [7:0] d, input bit pbit,
                        input bit stop_ok, input bit ff);
        exp_t       e;
        logic [7:0] last;
        last = p ? last_p : last_n;
        if (!stop_ok) begin
            e.vec  = 4'b0010;
            e.data = last;
        end else if (p && (((^d) ^ pbit) != 1'b0)) begin
            e.vec  = 4'b0001;
            e.data = last;
        end else begin
            e.vec  = {ff, 3'b100};
            e.data = d;
            if (p) last_p = d;
            else   last_n = d;
        end
        if (p) begin ff_p = ff; q_p.push_back(e); end
        else   begin ff_n = ff; q_n.push_back(e); end

        set_rx(p, 1'b0);
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            set_rx(p, d[i]);
            wait_clks(BIT_CLKS);
        end
        if (p) begin
            set_rx(p, pbit);
            wait_clks(BIT_CLKS);
        end
        if (stop_ok) begin
            set_rx(p, 1'b1);
            wait_clks(BIT_CLKS);
        end else begin
            // Low through the sampling point, high before the bit ends.
            set_rx(p, 1'b0);
            wait_clks(12 * DIV);
            set_rx(p, 1'b1);
            wait_clks(4 * DIV);
        end
    endtask

    task automatic glitch(input bit p);
        set_rx(p, 1'b0);
        wait_clks(4 * DIV);
        idle_bits(p, 2);
    endtask

    task automatic mon_dut(input bit p);
        logic [3:0] v;
        logic [7:0] d;
        exp_t       e;
        v = p ? {ov_p, done_p, fe_p, pe_p} : {ov_n, done_n, fe_n, pe_n};
        d = p ? data_p : data_n;
        if (v != 4'b0000) begin
            if ((p ? q_p.size() : q_n.size()) == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event dut%0d: got %0h expected none", p, v);
            end else begin
                e = p ? q_p.pop_front() : q_n.pop_front();
                check(p ? "event_p" : "event_n", 32'(v), 32'(e.vec));
                check(p ? "data_p" : "data_n", 32'(d), 32'(e.data));
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_data_n"}, 32'(data_n), 32'(last_n));
        check({tag, "_busy_n"}, 32'(busy_n), 32'd0);
        check({tag, "_data_p"}, 32'(data_p), 32'(last_p));
        check({tag, "_busy_p"}, 32'(busy_p), 32'd0);
    endtask

    initial begin
        fork
            begin : stimulus
                logic [7:0] d;
                bit         p, stop_ok, pbit, ff;

                wait_clks(3);
                #1 reset = 1'b0;
                @(negedge clk);
                check("rst_outs_n", 32'({done_n, fe_n, pe_n, ov_n}), 32'd0);
                check("rst_outs_p", 32'({done_p, fe_p, pe_p, ov_p}), 32'd0);
                check_quiet("rst");

                send(1'b0, 8'h55, 1'b0, 1'b1, 1'b0);
                idle_bits(1'b0, 1);
                check_quiet("after_55");

                glitch(1'b0);
                check_quiet("after_glitch");

                send(1'b0, 8'hA3, 1'b0, 1'b0, 1'b0);
                idle_bits(1'b0, 1);
                check_quiet("after_ferr");

                send(1'b0, 8'h3C, 1'b0, 1'b1, 1'b1);
                idle_bits(1'b0, 1);
                ff_n = 1'b0;

                send(1'b1, 8'h07, 1'b1, 1'b1, 1'b0);
                idle_bits(1'b1, 1);
                send(1'b1, 8'h07, 1'b0, 1'b1, 1'b0);
                idle_bits(1'b1, 1);
                check_quiet("after_parity");

                // Reset in the middle of the 4th data bit of 0xFF.
                set_rx(1'b0, 1'b0);
                wait_clks(BIT_CLKS);
                set_rx(1'b0, 1'b1);
                wait_clks(3 * BIT_CLKS + BIT_CLKS / 2);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                last_n = 8'h00;
                last_p = 8'h00;
                @(negedge clk);
                check("midrst_outs_n", 32'({done_n, fe_n, pe_n, ov_n}), 32'd0);
                check_quiet("midrst");
                wait_clks(BIT_CLKS / 2 + 5 * BIT_CLKS);
                send(1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
                idle_bits(1'b0, 1);
                check_quiet("after_81");

                for (int k = 0; k < 30; k++) begin
                    p = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 7) == 0) glitch(p);
                    d       = 8'($urandom);
                    stop_ok = ($urandom_range(0, 5) != 0);
                    pbit    = (^d) ^ ($urandom_range(0, 4) == 0);
                    ff      = ($urandom_range(0, 3) == 0);
                    send(p, d, pbit, stop_ok, ff);
                    if (!stop_ok) idle_bits(p, 1);
                    else          idle_bits(p, $urandom_range(0, 1));
                end
                ff_n = 1'b0;
                ff_p = 1'b0;
                idle_bits(1'b0, 2);
                check_quiet("final");
                stim_done = 1'b1;
            end
            begin : monitor
                while (!stim_done) begin
                    @(negedge clk);
                    mon_dut(1'b0);
                    mon_dut(1'b1);
                end
            end
        join
        check("pending_n", 32'(q_n.size()), 32'd0);
        check("pending_p", 32'(q_p.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive-side front end of the UART path: synchronizes the asynchronous serial line, oversamples it at 16x baud, and deframes start/data/parity/stop bits into parallel words. Each good word is presented with a one-cycle strobe that drives the receive FIFO's write request directly. Malformed frames are dropped and flagged. Words arriving while the FIFO is full are flagged as overruns.

## Interface
- DATA_BITS, 8, data bits per frame (5..8), sent LSB first
- SB_TICKS, 16, oversample ticks per stop-bit period (16 = 1 stop bit, 32 = 2 stop bits)
- PARITY_EN, 0, 1 = one parity bit follows the data bits
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity (only meaningful when PARITY_EN = 1)
- BAUD_DIVISOR, 651, clk cycles per oversample tick (100 MHz / (16 × 9600))
- clk  in  1  system clock; everything is on the rising edge
- reset  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial line; idles high
- fifo_full  in  1  full flag from the downstream receive FIFO
- rx_data  out  DATA_BITS  last deframed word; held until the next good frame
- rx_done_tick  out  1  one-cycle strobe marking a good frame; wired to the FIFO write request
- frame_error  out  1  one-cycle pulse: stop bit sampled low
- parity_error  out  1  one-cycle pulse: parity check failed
- overrun_error  out  1  one-cycle pulse: rx_done_tick fired while fifo_full = 1
- busy  out  1  high in any state other than IDLE

## Operation
- rx passes through a 2-flop synchronizer; the FSM only ever sees rx_s.
- The tick generator raises s_tick for one clk every BAUD_DIVISOR cycles. It free-runs, except a reset returns its count to 0.
- The FSM has states IDLE, START, DATA, PARITY, STOP.
- Two counters:
  - tick_cnt is 4 bits (5 bits when SB_TICKS = 32) and advances only on s_tick.
  - bit_cnt is 3 bits.
- IDLE: when rx_s = 0, go to START with tick_cnt = 0.
- START: on the s_tick where tick_cnt = 7 (mid start bit):
  - rx_s = 0 → go to DATA, clear tick_cnt and bit_cnt.
  - rx_s = 1 → glitch; return to IDLE with no outputs.
- DATA: on the s_tick where tick_cnt = 15:
  - shift register ← {rx_s, shreg[DATA_BITS-1:1]}; track the running XOR of the bits; clear tick_cnt.
  - After DATA_BITS samples, go to PARITY if PARITY_EN = 1, otherwise STOP.
- PARITY: at tick_cnt = 15, sample one bit.
  - The check passes when XOR(data) ^ bit ^ PARITY_ODD = 0.
  - Then go to STOP.
- STOP: sample rx_s at tick_cnt = 15 of the first stop bit.
  - When tick_cnt reaches SB_TICKS-1, evaluate the frame and return to IDLE on the same edge.
- Frame evaluation:
  - Stop sample = 0 → frame_error pulses; rx_done_tick stays low; rx_data is unchanged.
  - Otherwise, parity failed → parity_error pulses; rx_done_tick stays low; rx_data is unchanged.
  - Otherwise the frame is good: rx_data ← shreg, and rx_done_tick pulses.
  - A good frame with fifo_full = 1 also pulses overrun_error. rx_done_tick still pulses; the FIFO discards the write.
- At most one of frame_error and parity_error fires per frame. Frame error takes priority.
- When DATA_BITS < 8, the word is right-aligned in rx_data.

## Timing
- Reset values:
  - State IDLE, all counters 0, shreg 0, synchronizer flops 1.
  - rx_data = 0; rx_done_tick, frame_error, parity_error, overrun_error, busy = 0.
- A reset asserted mid-frame aborts the frame: no strobe, no error pulse, partial bits discarded. The next falling edge of rx_s starts a fresh frame.
- Synchronizer latency is 2 clk.
- Frame latency from the first sampled low on rx_s to rx_done_tick is 7 + 16·(DATA_BITS + PARITY_EN) + SB_TICKS ticks, ±1 tick of phase.
- rx_data updates on the same edge that raises rx_done_tick, so both are valid together for exactly one clk.
- Back-to-back frames: IDLE is re-entered at the end of the stop period. A start bit immediately following the stop bit is accepted with no lost frame.
- A line held low forever: each cycle through START → DATA → STOP produces a frame_error, then a new frame starts on the next low.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the oversample constant OS_TICKS = 16 and mid-bit constant MID_TICK = 7.
- Sub-module baud_rate_generator has parameter DIVISOR, ports clk, reset, s_tick. It is counter-based and may be shared with the transmitter.
- The synchronizer stays inline in the deserializer.

## Test plan
- 8N1, 0x55 sent at nominal baud → rx_data = 0x55 and exactly one rx_done_tick; no error pulses; busy low afterwards.
- rx low-glitch lasting 4 ticks → returns to IDLE from START; no rx_done_tick or error pulse; rx_data unchanged.
- Byte 0xA3 with stop bit forced 0 → frame_error pulses once; no rx_done_tick; rx_data keeps its previous value.
- PARITY_EN = 1, PARITY_ODD = 0:
  - 0x07 with parity bit 1 → good frame, rx_data = 0x07.
  - Same byte with parity bit 0 → parity_error only.
- fifo_full = 1 while 0x3C is received → rx_done_tick and overrun_error in the same cycle; rx_data = 0x3C.
- reset pulsed during the 4th data bit of 0xFF, then 0x81 sent → only one strobe, with rx_data = 0x81; outputs read 0 immediately after the reset.
